// File: rtl/capsense_scan_sequencer.sv
// Four-pad capacitive touch scanner: discharge/float cycle, per-pad charge-time capture,
// threshold classification and per-pad debounce of the touch state.
module capsense_scan_sequencer #(
  parameter int unsigned DISCHARGE_CYCLES = 64,
  parameter int unsigned TIMEOUT_CYCLES   = 255,
  parameter int unsigned THRESHOLD        = 20,
  parameter int unsigned DEBOUNCE         = 3,
  parameter int unsigned CNT_W            = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ENABLE,
  input  logic [3:0]         PAD_IN,
  output logic               BTN_SAMPLE,
  output logic [4*CNT_W-1:0] CHARGE_TIME,
  output logic [3:0]         TOUCHED,
  output logic [3:0]         PRESS_EVT,
  output logic               SCAN_DONE
);

  localparam int unsigned NPAD  = 4;
  localparam int unsigned DIS_W = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES + 1) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISCHARGE_CYCLES - 1);
  localparam logic [DIS_W-1:0] DIS_MAX  = {DIS_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DB_W-1:0]  DB_LIM   = DB_W'(DEBOUNCE);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DISCHARGE = 2'd1;
  localparam logic [1:0] S_FLOAT     = 2'd2;
  localparam logic [1:0] S_EVAL      = 2'd3;

  logic [NPAD-1:0]             sync1_q, sync2_q;
  logic [1:0]                  state_q, state_d;
  logic [DIS_W-1:0]            dis_cnt_q, dis_cnt_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NPAD-1:0]             latched_q, latched_d;
  logic [NPAD-1:0][CNT_W-1:0]  meas_q, meas_d;
  logic [NPAD-1:0][CNT_W-1:0]  charge_q, charge_d;
  logic [NPAD-1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [NPAD-1:0]             touched_q, touched_d;
  logic [NPAD-1:0]             press_evt_q, press_evt_d;
  logic                        scan_done_q, scan_done_d;
  logic                        btn_sample_q, btn_sample_d;

  logic [NPAD-1:0]             raw_c;
  logic [NPAD-1:0][DB_W-1:0]   db_inc_c;

  // Raw classification of the captured times and the debounce counter increment.
  always_comb begin
    raw_c    = '0;
    db_inc_c = '0;
    for (int i = 0; i < NPAD; i++) begin
      raw_c[i]    = (32'(meas_q[i]) >= THRESHOLD);
      db_inc_c[i] = db_cnt_q[i] + DB_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    dis_cnt_d   = dis_cnt_q;
    cnt_d       = cnt_q;
    latched_d   = latched_q;
    meas_d      = meas_q;
    charge_d    = charge_q;
    db_cnt_d    = db_cnt_q;
    touched_d   = touched_q;
    press_evt_d = '0;
    scan_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        dis_cnt_d = '0;
        cnt_d     = '0;
        if (ENABLE) state_d = S_DISCHARGE;
      end

      S_DISCHARGE: begin
        if (dis_cnt_q >= DIS_LAST) begin
          state_d   = S_FLOAT;
          dis_cnt_d = '0;
          cnt_d     = '0;
          latched_d = '0;
          meas_d    = '0;
        end else if (dis_cnt_q != DIS_MAX) begin
          dis_cnt_d = dis_cnt_q + DIS_W'(1);
        end
      end

      S_FLOAT: begin
        for (int i = 0; i < NPAD; i++) begin
          if (sync2_q[i] && !latched_q[i]) begin
            latched_d[i] = 1'b1;
            meas_d[i]    = cnt_q;
          end
        end
        // Leave once every pad has charged (this cycle included) or the window expires.
        if ((&latched_d) || (cnt_q >= CNT_LAST)) begin
          for (int i = 0; i < NPAD; i++) begin
            if (!latched_d[i]) meas_d[i] = CNT_TO;
          end
          state_d = S_EVAL;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_EVAL: begin
        charge_d    = meas_q;
        scan_done_d = 1'b1;
        dis_cnt_d   = '0;
        for (int i = 0; i < NPAD; i++) begin
          if (raw_c[i] == touched_q[i]) begin
            db_cnt_d[i] = '0;
          end else if (db_inc_c[i] >= DB_LIM) begin
            db_cnt_d[i]    = '0;
            touched_d[i]   = raw_c[i];
            press_evt_d[i] = raw_c[i];
          end else begin
            db_cnt_d[i] = db_inc_c[i];
          end
        end
        state_d = ENABLE ? S_DISCHARGE : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    btn_sample_d = (state_d == S_FLOAT);
  end

  // Pad synchronizer runs regardless of scan state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= PAD_IN;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      dis_cnt_q    <= '0;
      cnt_q        <= '0;
      latched_q    <= '0;
      meas_q       <= '0;
      charge_q     <= '0;
      db_cnt_q     <= '0;
      touched_q    <= '0;
      press_evt_q  <= '0;
      scan_done_q  <= 1'b0;
      btn_sample_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dis_cnt_q    <= dis_cnt_d;
      cnt_q        <= cnt_d;
      latched_q    <= latched_d;
      meas_q       <= meas_d;
      charge_q     <= charge_d;
      db_cnt_q     <= db_cnt_d;
      touched_q    <= touched_d;
      press_evt_q  <= press_evt_d;
      scan_done_q  <= scan_done_d;
      btn_sample_q <= btn_sample_d;
    end
  end

  assign BTN_SAMPLE  = btn_sample_q;
  assign CHARGE_TIME = charge_q;
  assign TOUCHED     = touched_q;
  assign PRESS_EVT   = press_evt_q;
  assign SCAN_DONE   = scan_done_q;

endmodule

// File: tb/tb_capsense_scan_sequencer.sv
// Scoreboard bench: directed per-scan pad rise delays with hand-computed scan results.
module tb_capsense_scan_sequencer;

  localparam int NEVER = 1000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ENABLE;
  logic [3:0]  PAD_IN;
  logic        BTN_SAMPLE;
  logic [31:0] CHARGE_TIME;
  logic [3:0]  TOUCHED;
  logic [3:0]  PRESS_EVT;
  logic        SCAN_DONE;

  capsense_scan_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .PAD_IN(PAD_IN),
    .BTN_SAMPLE(BTN_SAMPLE), .CHARGE_TIME(CHARGE_TIME), .TOUCHED(TOUCHED),
    .PRESS_EVT(PRESS_EVT), .SCAN_DONE(SCAN_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ct;
    logic [3:0]  t;
    logic [3:0]  p;
    int          period;
  } want_t;

  want_t want_q[$];
  int    delay[4];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    last_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Pad model: pins read High once the float window has lasted delay[i] cycles.
  initial begin
    int fc;
    fc = 0;
    PAD_IN = '0;
    for (int i = 0; i < 4; i++) delay[i] = NEVER;
    forever begin
      @(negedge CLK);
      if (BTN_SAMPLE === 1'b1) begin
        for (int i = 0; i < 4; i++) PAD_IN[i] = (fc >= delay[i]);
        fc++;
      end else begin
        PAD_IN = '0;
        fc = 0;
      end
    end
  end

  // Monitor: pops one expected record per SCAN_DONE pulse.
  initial begin
    want_t w;
    forever begin
      @(negedge CLK);
      cyc++;
      if (SCAN_DONE === 1'b1) begin
        if (want_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_scan_done: got 1 required 0 (t=%0t)", $time);
        end else begin
          w = want_q.pop_front();
          check("charge_time", CHARGE_TIME, w.ct);
          check("touched", 32'(TOUCHED), 32'(w.t));
          check("press_evt", 32'(PRESS_EVT), 32'(w.p));
          if (w.period != 0) check("scan_period", 32'(cyc - last_done), 32'(w.period));
        end
        last_done = cyc;
      end else if (PRESS_EVT !== 4'b0000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_press_evt: got %0h required 0 (t=%0t)", PRESS_EVT, $time);
      end
    end
  end

  task automatic wait_btn_high();
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (BTN_SAMPLE !== 1'b1 && k < 400);
    if (BTN_SAMPLE !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL btn_sample_timeout: got %0b required 1", BTN_SAMPLE);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (SCAN_DONE !== 1'b1 && k < 2000);
    if (SCAN_DONE !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scan_done_timeout: got %0b required 1", SCAN_DONE);
    end
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3,
                      input logic [31:0] ct, input logic [3:0] t, input logic [3:0] p,
                      input int period, input bit drop);
    want_t w;
    delay[0] = d0;
    delay[1] = d1;
    delay[2] = d2;
    delay[3] = d3;
    w.ct = ct;
    w.t = t;
    w.p = p;
    w.period = period;
    want_q.push_back(w);
    if (drop) begin
      wait_btn_high();
      repeat (10) @(negedge CLK);
      ENABLE = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    logic btn_seen;
    RST_N  = 1'b0;
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_btn_sample", 32'(BTN_SAMPLE), 32'd0);
    check("rst_touched", 32'(TOUCHED), 32'd0);
    check("rst_charge_time", CHARGE_TIME, 32'd0);
    check("rst_scan_done", 32'(SCAN_DONE), 32'd0);
    RST_N = 1'b1;
    btn_seen = 1'b0;
    repeat (50) begin
      @(negedge CLK);
      btn_seen |= BTN_SAMPLE;
    end
    check("idle_btn_sample", 32'(btn_seen), 32'd0);
    check("idle_touched", 32'(TOUCHED), 32'd0);

    // Nominal and touch on pad 2.
    ENABLE = 1'b1;
    scan(5, 5, 5, 5,        32'h07070707, 4'b0000, 4'b0000, 0,   1'b0);
    scan(5, 5, 5, 5,        32'h07070707, 4'b0000, 4'b0000, 73,  1'b0);
    scan(5, 5, 30, 5,       32'h07200707, 4'b0000, 4'b0000, 98,  1'b0);
    scan(5, 5, 30, 5,       32'h07200707, 4'b0000, 4'b0000, 98,  1'b0);
    scan(5, 5, 30, 5,       32'h07200707, 4'b0100, 4'b0100, 98,  1'b0);
    scan(5, 5, 30, 5,       32'h07200707, 4'b0100, 4'b0000, 98,  1'b0);
    // Timeout on pad 0.
    scan(NEVER, 5, 30, 5,   32'h072007FF, 4'b0100, 4'b0000, 320, 1'b0);
    scan(NEVER, 5, 30, 5,   32'h072007FF, 4'b0100, 4'b0000, 320, 1'b0);
    scan(NEVER, 5, 30, 5,   32'h072007FF, 4'b0101, 4'b0001, 320, 1'b0);
    // Bounce on pad 1.
    scan(NEVER, 30, 30, 5,  32'h072020FF, 4'b0101, 4'b0000, 320, 1'b0);
    scan(NEVER, 5, 30, 5,   32'h072007FF, 4'b0101, 4'b0000, 320, 1'b0);
    scan(NEVER, 30, 30, 5,  32'h072020FF, 4'b0101, 4'b0000, 320, 1'b0);
    scan(NEVER, 5, 30, 5,   32'h072007FF, 4'b0101, 4'b0000, 320, 1'b0);
    // ENABLE dropped mid-float: scan completes, then idle with state retained.
    scan(NEVER, 5, 30, 5,   32'h072007FF, 4'b0101, 4'b0000, 320, 1'b1);
    btn_seen = 1'b0;
    repeat (200) begin
      @(negedge CLK);
      btn_seen |= BTN_SAMPLE;
    end
    check("drop_idle_btn_sample", 32'(btn_seen), 32'd0);
    check("drop_idle_touched", 32'(TOUCHED), 32'h5);

    // Release needs three untouched scans; no event on release.
    ENABLE = 1'b1;
    scan(5, 5, 5, 5,        32'h07070707, 4'b0101, 4'b0000, 0,   1'b0);
    scan(5, 5, 5, 5,        32'h07070707, 4'b0101, 4'b0000, 73,  1'b0);
    scan(5, 5, 5, 5,        32'h07070707, 4'b0000, 4'b0000, 73,  1'b0);
    scan(5, 5, 5, 5,        32'h07070707, 4'b0000, 4'b0000, 73,  1'b0);

    // Reset mid-float.
    for (int i = 0; i < 4; i++) delay[i] = NEVER;
    wait_btn_high();
    repeat (20) @(negedge CLK);
    check("pre_rst_btn_sample", 32'(BTN_SAMPLE), 32'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_btn_sample", 32'(BTN_SAMPLE), 32'd0);
    check("midrst_charge_time", CHARGE_TIME, 32'd0);
    check("midrst_touched", 32'(TOUCHED), 32'd0);
    check("midrst_press_evt", 32'(PRESS_EVT), 32'd0);
    check("midrst_scan_done", 32'(SCAN_DONE), 32'd0);
    ENABLE = 1'b0;
    RST_N  = 1'b1;
    btn_seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      btn_seen |= BTN_SAMPLE;
    end
    check("post_rst_btn_sample", 32'(btn_seen), 32'd0);
    check("pending_scans", 32'(want_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
